// File: rtl/hamming_pkg.sv
// Shared types, default constants and the reference parity function for the
// Hamming(16,11) SECDED encoder engine.
package hamming_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_LO,
      RD_HI,
      WR_LO,
      WR_HI,
      DONE
   } state_t;

   localparam int NUM_MSG   = 15;
   localparam int SRC_BASE  = 0;
   localparam int DST_BASE  = 30;
   localparam int MEM_DEPTH = 256;

   // Word layout: {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}; p0 makes the whole word even parity.
   function automatic logic [15:0] encode16(input logic [11:1] d);
      logic p8, p4, p2, p1, p0;
      p8 = ^d[11:5];
      p4 = (^d[11:8]) ^ (^d[4:2]);
      p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
      p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
      p0 = (^d[11:1]) ^ p8 ^ p4 ^ p2 ^ p1;
      return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
   endfunction

endpackage

// File: rtl/hamming_data_mem.sv
// Byte-wide data memory: combinational read, synchronous write, contents
// deliberately untouched by reset so preloaded data survives.
module data_mem
   import hamming_pkg::*;
#(
   parameter int DEPTH = MEM_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] core [DEPTH];

   assign rdata = core[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         core[addr] <= wdata;
      end
   end

endmodule

// File: rtl/top_level.sv
// Hamming(16,11) SECDED encoder engine: reads packed 11-bit messages from its
// own data memory, encodes them and writes the 16-bit words back.
module top_level #(
   parameter int NUM_MSG   = hamming_pkg::NUM_MSG,
   parameter int SRC_BASE  = hamming_pkg::SRC_BASE,
   parameter int DST_BASE  = hamming_pkg::DST_BASE,
   parameter int MEM_DEPTH = hamming_pkg::MEM_DEPTH
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic done
);

   import hamming_pkg::*;

   localparam int AW = $clog2(MEM_DEPTH);
   localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
   localparam logic [AW-1:0] SRC_A  = AW'(SRC_BASE);
   localparam logic [AW-1:0] DST_A  = AW'(DST_BASE);
   localparam logic [IW-1:0] LAST_I = IW'(NUM_MSG - 1);

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [11:1]     d_q, d_d;
   logic            done_q, done_d;

   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [7:0]      mem_wdata;
   logic [7:0]      mem_rdata;
   logic [AW-1:0]   pair_off;
   logic [15:0]     code_word;

   data_mem #(
      .DEPTH (MEM_DEPTH),
      .AW    (AW)
   ) dm_ins (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: if (start) state_d = RD_LO;
         RD_LO:      state_d = RD_HI;
         RD_HI:      state_d = WR_LO;
         WR_LO:      state_d = WR_HI;
         WR_HI:      state_d = (idx_q == LAST_I) ? DONE : RD_LO;
         default:    state_d = IDLE;
      endcase
   end

   // Each message occupies a two-byte slot, so the slot offset is simply 2*index.
   assign pair_off  = AW'({idx_q, 1'b0});
   assign code_word = encode16(d_q);

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = code_word[7:0];
      unique case (state_q)
         RD_LO: mem_addr = SRC_A + pair_off;
         RD_HI: mem_addr = SRC_A + pair_off + AW'(1);
         WR_LO: begin
            mem_we   = 1'b1;
            mem_addr = DST_A + pair_off;
         end
         WR_HI: begin
            mem_we    = 1'b1;
            mem_addr  = DST_A + pair_off + AW'(1);
            mem_wdata = code_word[15:8];
         end
         default: mem_addr = '0;
      endcase
   end

   // done lags entry into DONE by one clock and is cleared by the edge that samples a rerun start.
   always_comb begin
      idx_d  = idx_q;
      d_d    = d_q;
      done_d = (state_q == DONE) && !start;
      unique case (state_q)
         IDLE, DONE: if (start) idx_d = '0;
         RD_LO:      d_d[8:1]  = mem_rdata;
         RD_HI:      d_d[11:9] = mem_rdata[2:0];
         WR_HI:      if (idx_q != LAST_I) idx_d = idx_q + IW'(1);
         default:    idx_d = idx_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q  <= '0;
         d_q    <= '0;
         done_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         d_q    <= d_d;
         done_q <= done_d;
      end
   end

   assign done = done_q;

endmodule

// File: tb/tb_top_level.sv
// Randomized self-checking bench for top_level, using a positional Hamming
// reference model and a shadow copy of the data memory.
module tb_top_level;

   localparam int NUM_MSG   = 15;
   localparam int DST_BASE  = 30;
   localparam int MEM_DEPTH = 256;
   localparam int RUN_CYC   = 4 * NUM_MSG + 1;
   localparam int BUDGET    = 300;

   logic clk;
   logic reset;
   logic start;
   logic done;

   logic [7:0] mem_model [MEM_DEPTH];
   logic [7:0] msg_lo    [NUM_MSG];
   logic [7:0] msg_hi    [NUM_MSG];
   int         err_count;
   int         check_count;
   int         cycles;

   top_level dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         err_count++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Bits sit at their code positions: parity at 1,2,4,8, data fills the rest in order,
   // parity p covers every position with bit p set, position 0 covers the whole word.
   function automatic logic [15:0] model_word(input logic [10:0] data);
      logic [15:0] w;
      int k;
      w = '0;
      k = 0;
      for (int pos = 1; pos < 16; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            w[pos] = data[k];
            k++;
         end
      end
      for (int p = 1; p < 16; p = p * 2) begin
         logic x;
         x = 1'b0;
         for (int pos = 1; pos < 16; pos++) begin
            if (pos != p && (pos & p) != 0) x = x ^ w[pos];
         end
         w[p] = x;
      end
      w[0] = ^w[15:1];
      return w;
   endfunction

   function automatic logic [15:0] dst_word(input int i);
      return {dut.dm_ins.core[DST_BASE + 2*i + 1], dut.dm_ins.core[DST_BASE + 2*i]};
   endfunction

   task automatic randomize_memory();
      for (int a = 0; a < MEM_DEPTH; a++) begin
         mem_model[a]        = 8'($urandom);
         dut.dm_ins.core[a]  = mem_model[a];
      end
   endtask

   task automatic random_messages();
      for (int i = 0; i < NUM_MSG; i++) begin
         msg_lo[i] = 8'($urandom);
         msg_hi[i] = 8'($urandom);
      end
   endtask

   task automatic load_messages();
      for (int i = 0; i < NUM_MSG; i++) begin
         mem_model[2*i]           = msg_lo[i];
         mem_model[2*i+1]         = msg_hi[i];
         dut.dm_ins.core[2*i]     = msg_lo[i];
         dut.dm_ins.core[2*i+1]   = msg_hi[i];
      end
   endtask

   // Pulse start, optionally keep it high or re-pulse it while busy, and count clocks to done.
   task automatic applyStimulus(input int hold, input int pulse_at, output int n);
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      checkOutput("done_clear", 32'(done), 32'd0);
      n = 0;
      start = (hold > 1);
      while (!done && n < BUDGET) begin
         @(posedge clk); #1;
         n++;
         start = (n < hold - 1) || (n == pulse_at);
      end
      start = 1'b0;
      if (!done) checkOutput("done_timeout", 32'(n), 32'(RUN_CYC));
   endtask

   // The first n_words encoded words must match the model; every other byte must be untouched.
   task automatic verifyMemory(input int n_words);
      for (int i = 0; i < n_words; i++) begin
         logic [15:0] w;
         w = model_word({msg_hi[i][2:0], msg_lo[i]});
         mem_model[DST_BASE + 2*i]     = w[7:0];
         mem_model[DST_BASE + 2*i + 1] = w[15:8];
         checkOutput($sformatf("word%0d", i), 32'(dst_word(i)), 32'(w));
      end
      for (int a = 0; a < MEM_DEPTH; a++) begin
         if (a < DST_BASE || a >= DST_BASE + 2*n_words) begin
            checkOutput($sformatf("keep%0d", a), 32'(dut.dm_ins.core[a]), 32'(mem_model[a]));
         end
      end
   endtask

   task automatic full_run(input int hold, input int pulse_at);
      applyStimulus(hold, pulse_at, cycles);
      checkOutput("done_cycles", 32'(cycles), 32'(RUN_CYC));
      verifyMemory(NUM_MSG);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("done_hold", 32'(done), 32'd1);
   endtask

   initial begin
      err_count   = 0;
      check_count = 0;
      reset = 1'b0;
      start = 1'b0;
      randomize_memory();
      #22;
      checkOutput("reset_done", 32'(done), 32'd0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("idle_done", 32'(done), 32'd0);

      $display("[TB] all-zero messages");
      for (int i = 0; i < NUM_MSG; i++) begin
         msg_lo[i] = 8'h00;
         msg_hi[i] = 8'h00;
      end
      load_messages();
      full_run(1, -1);
      for (int i = 0; i < NUM_MSG; i++) checkOutput("zero_word", 32'(dst_word(i)), 32'h0);

      $display("[TB] directed corner messages");
      random_messages();
      msg_hi[0] = 8'h07; msg_lo[0] = 8'hFF;
      msg_hi[1] = 8'h00; msg_lo[1] = 8'h01;
      msg_hi[2] = 8'h04; msg_lo[2] = 8'h00;
      msg_hi[3] = 8'hFC; msg_lo[3] = 8'h00;
      msg_hi[4] = 8'hFF; msg_lo[4] = 8'hFF;
      load_messages();
      full_run(1, -1);
      checkOutput("w_7ff",      32'(dst_word(0)), 32'hFFFF);
      checkOutput("w_001",      32'(dst_word(1)), 32'h000F);
      checkOutput("w_400",      32'(dst_word(2)), 32'h8117);
      checkOutput("w_400_junk", 32'(dst_word(3)), 32'h8117);
      checkOutput("w_7ff_junk", 32'(dst_word(4)), 32'hFFFF);

      $display("[TB] random messages, start held and re-pulsed while busy");
      for (int r = 0; r < 3; r++) begin
         randomize_memory();
         random_messages();
         load_messages();
         reset = 1'b0;
         #3;
         reset = 1'b1;
         full_run(int'($urandom_range(1, 12)), int'($urandom_range(5, 50)));
      end

      $display("[TB] rerun from DONE with fresh messages");
      random_messages();
      load_messages();
      full_run(1, -1);

      $display("[TB] reset mid-run");
      randomize_memory();
      random_messages();
      load_messages();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("midrun_done", 32'(done), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_hold_done", 32'(done), 32'd0);
      verifyMemory(5);
      reset = 1'b1;
      full_run(1, -1);

      $display("[TB] Result: errors=%0d of %0d checks", err_count, check_count);
      $finish;
   end

endmodule
